// File: rtl/dp_dr_pkg.sv
// dp_dr_pkg: shared phase encoding, bypass selector and default DR lengths
// Used by dp_dr_bank and dp_dr_chan.
package dp_dr_pkg;
  typedef enum logic [1:0] {IDLE, CAPTURED, SHIFTING} phase_e;
  typedef logic [7:0] sel_t;
  localparam sel_t BYPASS = 8'hFF;
  localparam int unsigned LEN_IDCODE = 32;
  localparam int unsigned LEN_DTMCS = 32;
  localparam int unsigned LEN_DMI = 41;
  localparam int unsigned LEN_BYPASS = 1;
  localparam logic [3:0][7:0] DEF_DR_LEN = {8'(LEN_DMI), 8'(LEN_DTMCS), 8'(LEN_DTMCS), 8'(LEN_IDCODE)};
endpackage

// File: rtl/dp_dr_chan.sv
// dp_dr_chan: one JTAG data register channel (shift register, update register, update pulse)
// Ports: tck/trst_n clock and async active-low reset; capture_i/shift_i/update_i
// already qualified by selection and priority; tdi_i serial in; cap_i capture value;
// tdo_o serial out (sr[0]); upd_o update register (zero-extended); vld_o one-cycle update pulse.
module dp_dr_chan #(
  parameter int W = 41,
  parameter int LEN = 32
) (
  input  logic         tck,
  input  logic         trst_n,
  input  logic         capture_i,
  input  logic         shift_i,
  input  logic         update_i,
  input  logic         tdi_i,
  input  logic [W-1:0] cap_i,
  output logic         tdo_o,
  output logic [W-1:0] upd_o,
  output logic         vld_o
);
  logic [LEN-1:0] sr_q, sr_d;
  logic [W-1:0] upd_q, upd_d;
  logic vld_q;
  logic unused_cap;
  // capture bits above LEN are intentionally ignored
  assign unused_cap = ^cap_i;
  assign tdo_o = sr_q[0];
  assign upd_o = upd_q;
  assign vld_o = vld_q;
  always_comb begin
    sr_d = capture_i ? cap_i[LEN-1:0] : shift_i ? LEN'({tdi_i, sr_q} >> 1) : sr_q;
    upd_d = update_i ? W'(sr_q) : upd_q;
  end
  always_ff @(posedge tck or negedge trst_n)
    if (!trst_n) begin
      sr_q <= '0;
      upd_q <= '0;
      vld_q <= 1'b0;
    end else begin
      sr_q <= sr_d;
      upd_q <= upd_d;
      vld_q <= update_i;
    end
endmodule

// File: rtl/dp_dr_bank.sv
// dp_dr_bank: bank of selectable JTAG data registers plus bypass, driven by TAP DR strobes
// Ports: tck clock, trst_n async active-low reset; dr_sel/sel_vld channel select (latched on
// capture_dr); capture_dr/shift_dr/update_dr phase strobes (capture > shift > update);
// tdi/tdo serial path; cap_data per-channel capture values; upd_data/upd_vld per-channel
// update registers and one-cycle pulses; len_err sticky length error.
// Optional: define DP_DR_LEN_CHECK_EN to add the shift-length check and len_err port.
module dp_dr_bank
  import dp_dr_pkg::*;
#(
  parameter int NUM_DR = 4,
  parameter int DR_W = 41,
  parameter logic [NUM_DR-1:0][7:0] DR_LEN = DEF_DR_LEN,
  localparam int SW = (NUM_DR > 1) ? $clog2(NUM_DR) : 1
) (
  input  logic                        tck,
  input  logic                        trst_n,
  input  logic [SW-1:0]               dr_sel,
  input  logic                        sel_vld,
  input  logic                        capture_dr,
  input  logic                        shift_dr,
  input  logic                        update_dr,
  input  logic                        tdi,
  output logic                        tdo,
  input  logic [NUM_DR-1:0][DR_W-1:0] cap_data,
  output logic [NUM_DR-1:0][DR_W-1:0] upd_data,
  output logic [NUM_DR-1:0]           upd_vld
`ifdef DP_DR_LEN_CHECK_EN
  ,
  output logic                        len_err
`endif
);
  sel_t sel_q, sel_d;
  phase_e phase_q, phase_d;
  logic [LEN_BYPASS-1:0] byp_q, byp_d;
  logic [SW-1:0] sel_idx;
  logic [NUM_DR-1:0] chan_tdo;
  logic byp, shift_en, upd_req, upd_en, len_ok;
  assign sel_idx = sel_q[SW-1:0];
  assign byp = sel_q == BYPASS;
  assign shift_en = shift_dr && !capture_dr;
  assign upd_req = update_dr && !capture_dr && !shift_dr;
  assign upd_en = upd_req && !byp && len_ok;
  assign tdo = byp ? byp_q[0] : chan_tdo[sel_idx];
  // capture uses the newly latched selection; shift/update use sel_q so dr_sel is ignored mid-scan
  always_comb begin
    sel_d = capture_dr ? ((sel_vld && int'(dr_sel) < NUM_DR) ? sel_t'(dr_sel) : BYPASS) : sel_q;
    byp_d = capture_dr ? '0 : (shift_en && byp) ? LEN_BYPASS'({tdi, byp_q} >> 1) : byp_q;
    phase_d = capture_dr ? CAPTURED :
              (shift_dr && phase_q != IDLE) ? SHIFTING :
              (update_dr && phase_q != IDLE) ? IDLE : phase_q;
  end
  always_ff @(posedge tck or negedge trst_n)
    if (!trst_n) begin
      sel_q <= BYPASS;
      byp_q <= '0;
      phase_q <= IDLE;
    end else begin
      sel_q <= sel_d;
      byp_q <= byp_d;
      phase_q <= phase_d;
    end
`ifdef DP_DR_LEN_CHECK_EN
  logic [7:0] cnt_q, cnt_d;
  logic err_q, err_d;
  assign len_ok = cnt_q == DR_LEN[sel_idx];
  assign len_err = err_q;
  always_comb begin
    cnt_d = capture_dr ? 8'd0 : (shift_en && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
    err_d = capture_dr ? 1'b0 : (upd_req && !byp && !len_ok) ? 1'b1 : err_q;
  end
  always_ff @(posedge tck or negedge trst_n)
    if (!trst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
`else
  assign len_ok = 1'b1;
`endif
  for (genvar i = 0; i < NUM_DR; i++) begin : g_ch
    dp_dr_chan #(.W(DR_W), .LEN(int'(DR_LEN[i]))) u_ch (
      .tck      (tck),
      .trst_n   (trst_n),
      .capture_i(capture_dr && sel_d == sel_t'(i)),
      .shift_i  (shift_en && sel_q == sel_t'(i)),
      .update_i (upd_en && sel_q == sel_t'(i)),
      .tdi_i    (tdi),
      .cap_i    (cap_data[i]),
      .tdo_o    (chan_tdo[i]),
      .upd_o    (upd_data[i]),
      .vld_o    (upd_vld[i])
    );
  end
endmodule

// File: tb/tb_dp_dr_bank.sv
// tb_dp_dr_bank: directed self-checking bench for dp_dr_bank
module tb_dp_dr_bank;
  logic tck = 1'b0;
  logic trst_n = 1'b0;
  logic [1:0] dr_sel = '0;
  logic sel_vld = 1'b0;
  logic capture_dr = 1'b0;
  logic shift_dr = 1'b0;
  logic update_dr = 1'b0;
  logic tdi = 1'b0;
  logic tdo;
  logic [3:0][40:0] cap_data = '0;
  logic [3:0][40:0] upd_data;
  logic [3:0] upd_vld;
`ifdef DP_DR_LEN_CHECK_EN
  logic len_err;
`endif
  int checks = 0;
  int errors = 0;

  always #5 tck = ~tck;

  dp_dr_bank dut (
    .tck       (tck),
    .trst_n    (trst_n),
    .dr_sel    (dr_sel),
    .sel_vld   (sel_vld),
    .capture_dr(capture_dr),
    .shift_dr  (shift_dr),
    .update_dr (update_dr),
    .tdi       (tdi),
    .tdo       (tdo),
    .cap_data  (cap_data),
    .upd_data  (upd_data),
    .upd_vld   (upd_vld)
`ifdef DP_DR_LEN_CHECK_EN
    ,
    .len_err   (len_err)
`endif
  );

  task automatic step();
    @(posedge tck);
    #1;
  endtask

  task automatic capture(input logic [1:0] s, input logic v);
    dr_sel = s;
    sel_vld = v;
    capture_dr = 1'b1;
    step();
    capture_dr = 1'b0;
  endtask

  task automatic shift1(input logic b);
    tdi = b;
    shift_dr = 1'b1;
    step();
    shift_dr = 1'b0;
  endtask

  task automatic update();
    update_dr = 1'b1;
    step();
    update_dr = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (tdo !== 1'b0) begin errors++; $display("FAIL reset_tdo: got %b want 0", tdo); end
    checks++;
    if (upd_vld !== 4'b0000) begin errors++; $display("FAIL reset_upd_vld: got %b want 0000", upd_vld); end
    checks++;
    if (upd_data !== '0) begin errors++; $display("FAIL reset_upd_data: got %h want 0", upd_data); end
`ifdef DP_DR_LEN_CHECK_EN
    checks++;
    if (len_err !== 1'b0) begin errors++; $display("FAIL reset_len_err: got %b want 0", len_err); end
`endif
    trst_n = 1'b1;
    step();
  endtask

  task automatic test_idcode_shift();
    logic [31:0] exp;
    exp = 32'h1234_5677;
    cap_data[0] = {9'h1FF, 32'h1234_5677};
    capture(2'd0, 1'b1);
    for (int k = 0; k < 32; k++) begin
      checks++;
      if (tdo !== exp[k]) begin errors++; $display("FAIL idcode_tdo bit %0d: got %b want %b", k, tdo, exp[k]); end
      shift1(1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (tdo !== 1'b0) begin errors++; $display("FAIL idcode_overflow %0d: got %b want 0", k, tdo); end
      shift1(1'b0);
    end
  endtask

  task automatic test_dmi_update();
    logic [40:0] v;
    v = 41'h1_0000_0003;
    cap_data[3] = 41'h0_0000_0002;
    capture(2'd3, 1'b1);
    for (int k = 0; k < 41; k++) shift1(v[k]);
    update();
    checks++;
    if (upd_vld !== 4'b1000) begin errors++; $display("FAIL dmi_vld_pulse: got %b want 1000", upd_vld); end
    checks++;
    if (upd_data[3] !== v) begin errors++; $display("FAIL dmi_upd_data: got %h want %h", upd_data[3], v); end
    step();
    checks++;
    if (upd_vld !== 4'b0000) begin errors++; $display("FAIL dmi_vld_one_cycle: got %b want 0000", upd_vld); end
    checks++;
    if (upd_data[3] !== v) begin errors++; $display("FAIL dmi_upd_hold: got %h want %h", upd_data[3], v); end
  endtask

  task automatic test_bypass();
    logic [2:0] bits, exp;
    bits = 3'b101;
    exp = 3'b010;
    capture(2'd2, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (tdo !== exp[k]) begin errors++; $display("FAIL bypass_tdo %0d: got %b want %b", k, tdo, exp[k]); end
      shift1(bits[k]);
    end
    update();
    checks++;
    if (upd_vld !== 4'b0000) begin errors++; $display("FAIL bypass_no_vld: got %b want 0000", upd_vld); end
    checks++;
    if (upd_data[2] !== 41'h0) begin errors++; $display("FAIL bypass_upd_data2: got %h want 0", upd_data[2]); end
    step();
  endtask

  task automatic test_sel_change();
    logic [31:0] c, v;
    c = 32'hCAFE_F00D;
    v = 32'h8765_4321;
    cap_data[1] = {9'h0, c};
    cap_data[2] = {9'h0, 32'h5A5A_5A5A};
    capture(2'd1, 1'b1);
    for (int k = 0; k < 32; k++) begin
      if (k == 16) dr_sel = 2'd2;
      checks++;
      if (tdo !== c[k]) begin errors++; $display("FAIL selchg_tdo bit %0d: got %b want %b", k, tdo, c[k]); end
      shift1(v[k]);
    end
    update();
    checks++;
    if (upd_vld !== 4'b0010) begin errors++; $display("FAIL selchg_vld: got %b want 0010", upd_vld); end
    checks++;
    if (upd_data[1] !== {9'h0, v}) begin errors++; $display("FAIL selchg_upd1: got %h want %h", upd_data[1], v); end
    checks++;
    if (upd_data[2] !== 41'h0) begin errors++; $display("FAIL selchg_upd2: got %h want 0", upd_data[2]); end
    step();
  endtask

  task automatic test_priority();
    cap_data[0] = 41'h1;
    dr_sel = 2'd0;
    sel_vld = 1'b1;
    tdi = 1'b0;
    capture_dr = 1'b1;
    shift_dr = 1'b1;
    update_dr = 1'b1;
    step();
    capture_dr = 1'b0;
    checks++;
    if (tdo !== 1'b1) begin errors++; $display("FAIL prio_capture_tdo: got %b want 1", tdo); end
    checks++;
    if (upd_vld !== 4'b0000) begin errors++; $display("FAIL prio_capture_vld: got %b want 0000", upd_vld); end
    step();
    shift_dr = 1'b0;
    update_dr = 1'b0;
    checks++;
    if (tdo !== 1'b0) begin errors++; $display("FAIL prio_shift_tdo: got %b want 0", tdo); end
    checks++;
    if (upd_vld !== 4'b0000) begin errors++; $display("FAIL prio_shift_vld: got %b want 0000", upd_vld); end
  endtask

  task automatic test_len_check();
    cap_data[3] = 41'h0;
    capture(2'd3, 1'b1);
    for (int k = 0; k < 40; k++) shift1(1'b1);
    update();
`ifdef DP_DR_LEN_CHECK_EN
    checks++;
    if (upd_vld !== 4'b0000) begin errors++; $display("FAIL len_vld_suppressed: got %b want 0000", upd_vld); end
    checks++;
    if (upd_data[3] !== 41'h1_0000_0003) begin errors++; $display("FAIL len_upd_unchanged: got %h want 10000000003", upd_data[3]); end
    checks++;
    if (len_err !== 1'b1) begin errors++; $display("FAIL len_err_set: got %b want 1", len_err); end
    step();
    checks++;
    if (len_err !== 1'b1) begin errors++; $display("FAIL len_err_sticky: got %b want 1", len_err); end
    capture(2'd3, 1'b1);
    checks++;
    if (len_err !== 1'b0) begin errors++; $display("FAIL len_err_clear: got %b want 0", len_err); end
`else
    checks++;
    if (upd_vld !== 4'b1000) begin errors++; $display("FAIL nolen_vld: got %b want 1000", upd_vld); end
    checks++;
    if (upd_data[3] !== 41'h1FF_FFFF_FFFE) begin errors++; $display("FAIL nolen_upd: got %h want 1fffffffffe", upd_data[3]); end
    step();
`endif
  endtask

  task automatic test_reset_mid_shift();
    cap_data[0] = {9'h0, 32'hFFFF_FFFF};
    capture(2'd0, 1'b1);
    for (int k = 0; k < 9; k++) shift1(1'b1);
    tdi = 1'b1;
    shift_dr = 1'b1;
    #2 trst_n = 1'b0;
    #1;
    checks++;
    if (tdo !== 1'b0) begin errors++; $display("FAIL rst_mid_tdo: got %b want 0", tdo); end
    checks++;
    if (upd_vld !== 4'b0000) begin errors++; $display("FAIL rst_mid_vld: got %b want 0000", upd_vld); end
    checks++;
    if (upd_data !== '0) begin errors++; $display("FAIL rst_mid_upd_data: got %h want 0", upd_data); end
`ifdef DP_DR_LEN_CHECK_EN
    checks++;
    if (len_err !== 1'b0) begin errors++; $display("FAIL rst_mid_len_err: got %b want 0", len_err); end
`endif
    shift_dr = 1'b0;
    update_dr = 1'b1;
    step();
    update_dr = 1'b0;
    checks++;
    if (upd_vld !== 4'b0000) begin errors++; $display("FAIL rst_held_vld: got %b want 0000", upd_vld); end
    trst_n = 1'b1;
    step();
    checks++;
    if (upd_vld !== 4'b0000) begin errors++; $display("FAIL rst_release_vld: got %b want 0000", upd_vld); end
    shift1(1'b1);
    checks++;
    if (tdo !== 1'b1) begin errors++; $display("FAIL rst_sel_bypass: got %b want 1", tdo); end
    update();
    checks++;
    if (upd_vld !== 4'b0000) begin errors++; $display("FAIL rst_bypass_update: got %b want 0000", upd_vld); end
    step();
  endtask

  initial begin
    test_reset();
    test_idcode_shift();
    test_dmi_update();
    test_bypass();
    test_sel_change();
    test_priority();
    test_len_check();
    test_reset_mid_shift();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
